// File: rtl/byte_joining_ctrl.sv
// Byte-joining sequencer: capture strobe, lane-select stepping, alignment/loss/overrun tracking.
// Optional group statistics counter enabled by defining BJ_CTRL_STATS_EN.
module byte_joining_ctrl #(
    parameter int unsigned ALIGN_HOLD = 2,
    parameter int unsigned STAT_W     = 16
) (
    input  logic              clk1M,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        lane_mode,
    input  logic [3:0]        lanes_ready,
    input  logic              word_stb,
    output logic              load_stb,
    output logic [1:0]        ctr_3,
    output logic              out_valid,
    output logic              busy,
    output logic              err_overrun,
    output logic              err_lane,
    output logic [STAT_W-1:0] group_count
);

    typedef enum logic [1:0] {StIdle, StAlign, StRun, StDrain} state_e;

    localparam logic [3:0] HoldCnt = 4'(ALIGN_HOLD);

    state_e     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [3:0] align_q, align_d;
    logic [1:0] guard_q, guard_d;   // cycles left before another strobe may be accepted
    logic       load_q, load_d;
    logic       valid_q, valid_d;
    logic [1:0] ctr_q, ctr_d;
    logic       busy_q, busy_d;
    logic       err_ov_q, err_ov_d;
    logic       err_lane_q, err_lane_d;

    logic [3:0] act_mask;
    logic [1:0] last_idx;
    logic       lanes_ok;

    always_comb begin
        act_mask = 4'b1111;
        last_idx = 2'd3;
        case (mode_q)
            2'b00: begin
                act_mask = 4'b0001;
                last_idx = 2'd0;
            end
            2'b01: begin
                act_mask = 4'b0011;
                last_idx = 2'd1;
            end
            default: begin
                act_mask = 4'b1111;
                last_idx = 2'd3;
            end
        endcase
    end

    assign lanes_ok = (lanes_ready & act_mask) == act_mask;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        align_d    = align_q;
        guard_d    = (guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0;
        load_d     = 1'b0;
        valid_d    = 1'b0;
        ctr_d      = 2'd0;
        err_ov_d   = err_ov_q;
        err_lane_d = err_lane_q;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    mode_d     = lane_mode;
                    align_d    = 4'd0;
                    guard_d    = 2'd0;
                    err_ov_d   = 1'b0;
                    err_lane_d = 1'b0;
                    state_d    = StAlign;
                end
            end
            StAlign: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (lanes_ok) begin
                    if (align_q + 4'd1 == HoldCnt) begin
                        state_d = StRun;
                        align_d = 4'd0;
                    end else begin
                        align_d = align_q + 4'd1;
                    end
                end else begin
                    align_d = 4'd0;
                end
            end
            StRun, StDrain: begin
                if (!lanes_ok) begin
                    // Lane loss wins over any strobe and aborts the group in flight
                    err_lane_d = 1'b1;
                    align_d    = 4'd0;
                    guard_d    = 2'd0;
                    state_d    = enable ? StAlign : StIdle;
                end else begin
                    if (load_q) begin
                        valid_d = 1'b1;
                        ctr_d   = 2'd0;
                    end else if (valid_q && ctr_q != last_idx) begin
                        valid_d = 1'b1;
                        ctr_d   = ctr_q + 2'd1;
                    end
                    if (state_q == StRun) begin
                        if (enable && word_stb) begin
                            if (guard_q == 2'd0) begin
                                load_d  = 1'b1;
                                guard_d = last_idx;
                            end else begin
                                err_ov_d = 1'b1;
                            end
                        end
                        if (!enable) begin
                            state_d = (load_d || valid_d) ? StDrain : StIdle;
                        end
                    end else if (!load_d && !valid_d) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk1M) begin
        if (reset) begin
            state_q    <= StIdle;
            mode_q     <= 2'b00;
            align_q    <= 4'd0;
            guard_q    <= 2'd0;
            load_q     <= 1'b0;
            valid_q    <= 1'b0;
            ctr_q      <= 2'd0;
            busy_q     <= 1'b0;
            err_ov_q   <= 1'b0;
            err_lane_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            align_q    <= align_d;
            guard_q    <= guard_d;
            load_q     <= load_d;
            valid_q    <= valid_d;
            ctr_q      <= ctr_d;
            busy_q     <= busy_d;
            err_ov_q   <= err_ov_d;
            err_lane_q <= err_lane_d;
        end
    end

    assign load_stb    = load_q;
    assign ctr_3       = ctr_q;
    assign out_valid   = valid_q;
    assign busy        = busy_q;
    assign err_overrun = err_ov_q;
    assign err_lane    = err_lane_q;

`ifdef BJ_CTRL_STATS_EN
    logic [STAT_W-1:0] grp_q;

    // A group counts once its last byte has been presented as valid
    always_ff @(posedge clk1M) begin
        if (reset) begin
            grp_q <= '0;
        end else if (valid_q && ctr_q == last_idx && grp_q != '1) begin
            grp_q <= grp_q + STAT_W'(1);
        end
    end

    assign group_count = grp_q;
`else
    assign group_count = '0;
`endif

endmodule

// File: tb/tb_byte_joining_ctrl.sv
// Randomized and directed bench for byte_joining_ctrl against a schedule-based reference model.
module tb_byte_joining_ctrl;

    localparam int unsigned AlignHold = 2;
    localparam int unsigned StatW     = 16;
    localparam int          MIdle     = 0;
    localparam int          MAlign    = 1;
    localparam int          MRun      = 2;
    localparam int          MDrain    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [1:0]       lane_mode;
    logic [3:0]       lanes_ready;
    logic             word_stb;
    logic             load_stb;
    logic [1:0]       ctr_3;
    logic             out_valid;
    logic             busy;
    logic             err_overrun;
    logic             err_lane;
    logic [StatW-1:0] group_count;

    always #5 clk = ~clk;

    byte_joining_ctrl #(
        .ALIGN_HOLD(AlignHold),
        .STAT_W    (StatW)
    ) dut (
        .clk1M      (clk),
        .reset      (reset),
        .enable     (enable),
        .lane_mode  (lane_mode),
        .lanes_ready(lanes_ready),
        .word_stb   (word_stb),
        .load_stb   (load_stb),
        .ctr_3      (ctr_3),
        .out_valid  (out_valid),
        .busy       (busy),
        .err_overrun(err_overrun),
        .err_lane   (err_lane),
        .group_count(group_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: accepted strobes schedule future load/byte events by absolute cycle
    int       cyc = 0;
    int       m_state = MIdle;
    int       m_n = 1;
    logic [3:0] m_mask = 4'b0001;
    int       m_hold = 0;
    int       m_last_acc = -1000;
    bit       m_ov = 0;
    bit       m_ln = 0;
    int       m_groups = 0;
    int       sched_load[int];
    int       sched_byte[int];

    logic       e_load, e_valid, e_busy;
    logic [1:0] e_ctr;

    int cur_mode_i = 2;
    int obs_valid = 0;
    int run_len = 0;
    int max_run = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic en, input logic [1:0] mode,
                              input logic [3:0] rdy, input logic stb);
        int  c;
        bit  ok;
        c = cyc;
        if (rst) begin
            m_state    = MIdle;
            m_hold     = 0;
            m_last_acc = -1000;
            m_ov       = 0;
            m_ln       = 0;
            m_groups   = 0;
            sched_load.delete();
            sched_byte.delete();
        end else begin
            if (sched_byte.exists(c) && sched_byte[c] == m_n - 1 && m_groups < (1 << StatW) - 1)
                m_groups++;
            sched_load.delete(c);
            sched_byte.delete(c);
            ok = ((rdy & m_mask) == m_mask);
            case (m_state)
                MIdle: begin
                    if (en) begin
                        m_n        = (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : 4;
                        m_mask     = 4'((1 << m_n) - 1);
                        m_hold     = 0;
                        m_ov       = 0;
                        m_ln       = 0;
                        m_last_acc = -1000;
                        m_state    = MAlign;
                    end
                end
                MAlign: begin
                    if (!en) m_state = MIdle;
                    else if (ok) begin
                        m_hold++;
                        if (m_hold == AlignHold) begin
                            m_state = MRun;
                            m_hold  = 0;
                        end
                    end else m_hold = 0;
                end
                default: begin
                    if (!ok) begin
                        sched_load.delete();
                        sched_byte.delete();
                        m_ln       = 1;
                        m_hold     = 0;
                        m_last_acc = -1000;
                        m_state    = en ? MAlign : MIdle;
                    end else if (m_state == MRun) begin
                        if (en && stb) begin
                            if (c - m_last_acc >= m_n) begin
                                sched_load[c+1] = 1;
                                for (int i = 0; i < m_n; i++) sched_byte[c+2+i] = i;
                                m_last_acc = c;
                            end else m_ov = 1;
                        end
                        if (!en)
                            m_state = (sched_load.num() + sched_byte.num() > 0) ? MDrain : MIdle;
                    end else if (sched_load.num() + sched_byte.num() == 0) begin
                        m_state = MIdle;
                    end
                end
            endcase
        end
        cyc++;
        e_load  = sched_load.exists(cyc);
        e_valid = sched_byte.exists(cyc);
        e_ctr   = e_valid ? 2'(sched_byte[cyc]) : 2'd0;
        e_busy  = (m_state != MIdle);
    endtask

    task automatic cycle_step(input logic rst, input logic en, input logic [1:0] mode,
                              input logic [3:0] rdy, input logic stb);
        @(negedge clk);
        reset       = rst;
        enable      = en;
        lane_mode   = mode;
        lanes_ready = rdy;
        word_stb    = stb;
        model_step(rst, en, mode, rdy, stb);
        @(posedge clk);
        #1;
        check_eq("load_stb", 32'(load_stb), 32'(e_load));
        check_eq("out_valid", 32'(out_valid), 32'(e_valid));
        check_eq("ctr_3", 32'(ctr_3), 32'(e_ctr));
        check_eq("busy", 32'(busy), 32'(e_busy));
        check_eq("err_overrun", 32'(err_overrun), 32'(m_ov));
        check_eq("err_lane", 32'(err_lane), 32'(m_ln));
`ifdef BJ_CTRL_STATS_EN
        check_eq("group_count", 32'(group_count), 32'(m_groups));
`else
        check_eq("group_count", 32'(group_count), 32'd0);
`endif
        if (out_valid) begin
            obs_valid++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else run_len = 0;
    endtask

    task automatic run_step(input logic stb);
        cycle_step(1'b0, 1'b1, 2'(cur_mode_i), 4'hF, stb);
    endtask

    task automatic go_run(input int mode);
        cur_mode_i = mode;
        cycle_step(1'b1, 1'b0, 2'(mode), 4'hF, 1'b0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 20 && m_state != MRun; i++) run_step(1'b0);
        check_eq("reach_run", 32'(m_state == MRun), 32'd1);
        obs_valid = 0;
        run_len   = 0;
        max_run   = 0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; lane_mode = 2'b00; lanes_ready = 4'h0; word_stb = 1'b0;

        // Single x4 group latency and lane order
        go_run(2);
        run_step(1'b1);
        check_eq("t1_load", 32'(load_stb), 32'd1);
        for (int i = 0; i < 4; i++) begin
            run_step(1'b0);
            check_eq("t1_valid", 32'(out_valid), 32'd1);
            check_eq("t1_ctr", 32'(ctr_3), 32'(i));
        end
        run_step(1'b0);
        check_eq("t1_end", 32'(out_valid), 32'd0);

        // Back-to-back x4 groups give a gapless stream
        go_run(2);
        for (int g = 0; g < 8; g++) begin
            run_step(1'b1);
            for (int i = 0; i < 3; i++) run_step(1'b0);
        end
        for (int i = 0; i < 6; i++) run_step(1'b0);
        check_eq("t2_run", 32'(max_run), 32'd32);
        check_eq("t2_ovr", 32'(err_overrun), 32'd0);
`ifdef BJ_CTRL_STATS_EN
        check_eq("t2_groups", 32'(group_count), 32'd8);
`endif

        // x2 overrun drops the second strobe
        go_run(1);
        run_step(1'b1);
        run_step(1'b1);
        for (int i = 0; i < 5; i++) run_step(1'b0);
        check_eq("t3_ovr", 32'(err_overrun), 32'd1);
        check_eq("t3_bytes", 32'(obs_valid), 32'd2);

        // Lane loss during byte 2
        go_run(2);
        run_step(1'b1);
        run_step(1'b0);
        run_step(1'b0);
        run_step(1'b0);
        check_eq("t4_ctr2", 32'(ctr_3), 32'd2);
        cycle_step(1'b0, 1'b1, 2'd2, 4'b1011, 1'b0);
        check_eq("t4_valid", 32'(out_valid), 32'd0);
        check_eq("t4_err", 32'(err_lane), 32'd1);
        check_eq("t4_busy", 32'(busy), 32'd1);
        check_eq("t4_groups", 32'(group_count), 32'd0);
        for (int i = 0; i < 4; i++) run_step(1'b0);

        // Enable drops in the load cycle: drain finishes, strobe in drain ignored
        go_run(2);
        run_step(1'b1);
        cycle_step(1'b0, 1'b0, 2'd2, 4'hF, 1'b0);
        cycle_step(1'b0, 1'b0, 2'd2, 4'hF, 1'b1);
        for (int i = 0; i < 6; i++) cycle_step(1'b0, 1'b0, 2'd2, 4'hF, 1'b0);
        check_eq("t5_bytes", 32'(obs_valid), 32'd4);
        check_eq("t5_busy", 32'(busy), 32'd0);

        // Reset mid-group, then mode change while running
        go_run(2);
        run_step(1'b1);
        run_step(1'b0);
        run_step(1'b0);
        cycle_step(1'b1, 1'b1, 2'd2, 4'hF, 1'b0);
        check_eq("t6_valid", 32'(out_valid), 32'd0);
        check_eq("t6_ctr", 32'(ctr_3), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        go_run(1);
        cycle_step(1'b0, 1'b1, 2'd2, 4'hF, 1'b1);
        for (int i = 0; i < 5; i++) cycle_step(1'b0, 1'b1, 2'd2, 4'hF, 1'b0);
        check_eq("t6_x2bytes", 32'(obs_valid), 32'd2);

        // Randomized traffic
        begin
            logic en_r;
            en_r = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                logic       rst_r;
                logic [3:0] rdy_r;
                rst_r = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 59) == 0) en_r = ~en_r;
                rdy_r = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'hF;
                cycle_step(rst_r, en_r, 2'($urandom), rdy_r, ($urandom_range(0, 2) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
